// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-Lite codes, responder state encoding and lane-merge helper
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Replace the bytes of old_w selected by mask with the same bytes of new_w.
  function automatic logic [63:0] lane_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    res = old_w;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahbl_byte_mask.sv
// rtl/ahbl_byte_mask.sv - byte-lane mask and misalignment flag from transfer size and low address bits
module ahbl_byte_mask
  import ahbl_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [2:0] i_addr,
  output logic [7:0] o_mask,
  output logic       o_misaligned
);

  always_comb begin
    o_mask       = 8'h00;
    o_misaligned = 1'b0;
    case (i_size)
      HSIZE_BYTE: o_mask = 8'h01 << i_addr;
      HSIZE_HALF: begin
        o_mask       = 8'h03 << {i_addr[2:1], 1'b0};
        o_misaligned = i_addr[0];
      end
      HSIZE_WORD: begin
        o_mask       = 8'h0F << {i_addr[2], 2'b00};
        o_misaligned = |i_addr[1:0];
      end
      HSIZE_DWORD: begin
        o_mask       = 8'hFF;
        o_misaligned = |i_addr;
      end
      default: o_mask = 8'h00;
    endcase
  end

endmodule

// File: rtl/ahbl_sram_responder.sv
// rtl/ahbl_sram_responder.sv - AHB-Lite SRAM responder, 64-bit, programmable wait states, ERROR responses
module ahbl_sram_responder
  import ahbl_pkg::*;
#(
  parameter int DW      = 64,
  parameter int AW      = 12,
  parameter int WAIT_ST = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [DW-1:0] HRDATA,
  output logic          HRESP
);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_wcnt;
  logic            r_wr_pend;
  logic [AW-1:0]   r_waddr;
  logic [7:0]      r_wmask;
  logic [DW-1:0]   r_hrdata;
  logic [DW-1:0]   r_mem [2**AW];

  logic            w_xfer;
  logic            w_accept;
  logic            w_bad;
  logic            w_misal;
  logic            w_commit;
  logic            w_fwd;
  logic [7:0]      w_mask;
  logic [AW-1:0]   w_idx;
  logic [DW-1:0]   w_rd_word;

  ahbl_byte_mask u_byte_mask (
    .i_size       (HSIZE),
    .i_addr       (HADDR[2:0]),
    .o_mask       (w_mask),
    .o_misaligned (w_misal)
  );

  assign w_xfer    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign w_accept  = w_xfer & ((r_state == ST_IDLE) | (r_state == ST_LAST) | (r_state == ST_ERR2));
  assign w_idx     = HADDR[AW+2:3];
  assign w_bad     = w_misal | HSIZE[2] | (|HADDR[31:AW+3]);
  // A pending write completes on the edge that ends its zero-wait or LAST data cycle.
  assign w_commit  = r_wr_pend & ((r_state == ST_IDLE) | (r_state == ST_LAST));
  assign w_rd_word = r_mem[w_idx];
  assign w_fwd     = w_commit & (r_waddr == w_idx);

  always_comb begin
    w_next    = r_state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        HRESP = (r_state == ST_ERR2);
        if (w_accept) begin
          if (w_bad)            w_next = ST_ERR1;
          else if (WAIT_ST > 0) w_next = ST_WAIT;
          else                  w_next = ST_IDLE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_wcnt == 4'd0) w_next = ST_LAST;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        w_next    = ST_ERR2;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= 4'd0;
      r_wr_pend <= 1'b0;
      r_waddr   <= '0;
      r_wmask   <= 8'h00;
      r_hrdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && !w_bad)               r_wcnt <= 4'(WAIT_ST - 1);
      else if (r_state == ST_WAIT && r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
      if (w_accept) begin
        r_wr_pend <= ~w_bad & HWRITE;
        r_waddr   <= w_idx;
        r_wmask   <= w_mask;
      end else if (w_commit) begin
        r_wr_pend <= 1'b0;
      end
      if (w_accept && !w_bad && !HWRITE)
        r_hrdata <= w_fwd ? lane_merge(w_rd_word, HWDATA, r_wmask) : w_rd_word;
    end
  end

  // Storage has no reset so contents survive a mid-transfer reset.
  always_ff @(posedge HCLK) begin
    if (w_commit) r_mem[r_waddr] <= lane_merge(r_mem[r_waddr], HWDATA, r_wmask);
  end

  assign HRDATA = r_hrdata;

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// tb/tb_ahbl_sram_responder.sv - directed and randomized self-checking bench for ahbl_sram_responder
module tb_ahbl_sram_responder;
  import ahbl_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel0, hsel3;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [63:0] HWDATA;
  logic        rdy0, rdy3, resp0, resp3;
  logic [63:0] rd0, rd3;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [63:0] ref_mem [8];

  always #5 HCLK = ~HCLK;

  ahbl_sram_responder #(.DW(64), .AW(12), .WAIT_ST(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRDATA(rd0), .HRESP(resp0)
  );

  ahbl_sram_responder #(.DW(64), .AW(12), .WAIT_ST(3)) u_dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(rdy3),
    .HREADYOUT(rdy3), .HRDATA(rd3), .HRESP(resp3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single non-pipelined transfer; returns data, number of low HREADYOUT cycles and HRESP at first/last data cycle.
  task automatic do_xfer(input bit d3, input logic [31:0] a, input logic [2:0] sz, input bit wr,
                         input logic [63:0] wd, output logic [63:0] rd, output int waits,
                         output bit resp_first, output bit resp_last);
    @(negedge HCLK);
    hsel0 = !d3; hsel3 = d3; HADDR = a; HTRANS = HTRANS_NONSEQ; HSIZE = sz; HWRITE = wr;
    @(negedge HCLK);
    hsel0 = 1'b0; hsel3 = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wd;
    waits = 0;
    resp_first = d3 ? resp3 : resp0;
    while (!(d3 ? rdy3 : rdy0) && waits < 20) begin
      waits++;
      @(negedge HCLK);
    end
    resp_last = d3 ? resp3 : resp0;
    rd = d3 ? rd3 : rd0;
  endtask

  initial begin
    logic [63:0] rdv, t4_val, p_wd, p_exp, wd, t;
    int          w, word, sz, off, kind;
    bit          rf, rl, p_valid, p_wr, wr;

    HRESETn = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE;
    HSIZE = HSIZE_BYTE; HWRITE = 1'b0; HWDATA = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_ready0", 64'(rdy0), 64'd1);
    chk("rst_resp0", 64'(resp0), 64'd0);
    chk("rst_rdata0", rd0, 64'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_ready3", 64'(rdy3), 64'd1);
    chk("rst_rdata3", rd3, 64'd0);

    do_xfer(0, 32'h0, HSIZE_DWORD, 1, 64'h1122334455667788, rdv, w, rf, rl);
    chk("t1_wr_waits", 64'(w), 64'd0);
    chk("t1_wr_resp", 64'(rf | rl), 64'd0);
    do_xfer(0, 32'h0, HSIZE_DWORD, 0, 64'h0, rdv, w, rf, rl);
    chk("t1_rd_waits", 64'(w), 64'd0);
    chk("t1_rd_data", rdv, 64'h1122334455667788);

    do_xfer(0, 32'h0, HSIZE_DWORD, 1, 64'h0, rdv, w, rf, rl);
    do_xfer(0, 32'h5, HSIZE_BYTE, 1, 64'hEEEEABEEEEEEEEEE, rdv, w, rf, rl);
    chk("t2_wr_resp", 64'(rl), 64'd0);
    do_xfer(0, 32'h0, HSIZE_WORD, 0, 64'h0, rdv, w, rf, rl);
    chk("t2_rd_data", rdv, 64'h0000AB0000000000);

    do_xfer(0, 32'h8, HSIZE_DWORD, 1, 64'h0102030405060708, rdv, w, rf, rl);
    @(negedge HCLK);
    hsel0 = 1'b1; HADDR = 32'hC; HTRANS = HTRANS_NONSEQ; HSIZE = HSIZE_WORD; HWRITE = 1'b1;
    @(negedge HCLK);
    chk("t3_wr_ready", 64'(rdy0), 64'd1);
    HWDATA = 64'hDEADBEEF_00000000; HADDR = 32'h8; HSIZE = HSIZE_DWORD; HWRITE = 1'b0;
    @(negedge HCLK);
    hsel0 = 1'b0; HTRANS = HTRANS_IDLE;
    chk("t3_rd_ready", 64'(rdy0), 64'd1);
    chk("t3_fwd_data", rd0, 64'hDEADBEEF05060708);

    t4_val = 64'h0F1E2D3C4B5A6978;
    do_xfer(1, 32'h10, HSIZE_DWORD, 1, t4_val, rdv, w, rf, rl);
    chk("t4_wr_waits", 64'(w), 64'd3);
    do_xfer(1, 32'h10, HSIZE_DWORD, 0, 64'h0, rdv, w, rf, rl);
    chk("t4_rd_waits", 64'(w), 64'd3);
    chk("t4_rd_resp", 64'(rf | rl), 64'd0);
    chk("t4_rd_data", rdv, t4_val);

    do_xfer(0, 32'h3, HSIZE_HALF, 1, 64'hFFFFFFFFFFFFFFFF, rdv, w, rf, rl);
    chk("t5_half_waits", 64'(w), 64'd1);
    chk("t5_half_resp", {62'd0, rf, rl}, 64'd3);
    do_xfer(0, 32'h8000, HSIZE_WORD, 0, 64'h0, rdv, w, rf, rl);
    chk("t5_oor_waits", 64'(w), 64'd1);
    chk("t5_oor_resp", {62'd0, rf, rl}, 64'd3);
    chk("t5_oor_hold", rdv, 64'hDEADBEEF05060708);
    do_xfer(0, 32'h0, HSIZE_DWORD, 0, 64'h0, rdv, w, rf, rl);
    chk("t5_mem_intact", rdv, 64'h0000AB0000000000);
    do_xfer(1, 32'h12, HSIZE_WORD, 1, 64'h0, rdv, w, rf, rl);
    chk("t5_w3_waits", 64'(w), 64'd1);
    chk("t5_w3_resp", {62'd0, rf, rl}, 64'd3);
    do_xfer(1, 32'h10, 3'b100, 0, 64'h0, rdv, w, rf, rl);
    chk("t5_size_resp", {62'd0, rf, rl}, 64'd3);
    chk("t5_w3_hold", rdv, t4_val);

    @(negedge HCLK);
    hsel3 = 1'b1; HADDR = 32'h10; HTRANS = HTRANS_NONSEQ; HSIZE = HSIZE_DWORD; HWRITE = 1'b1;
    @(negedge HCLK);
    hsel3 = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 64'hBAD0BAD0BAD0BAD0;
    chk("t6_in_wait", 64'(rdy3), 64'd0);
    #1 HRESETn = 1'b0;
    #1;
    chk("t6_rst_ready", 64'(rdy3), 64'd1);
    chk("t6_rst_resp", 64'(resp3), 64'd0);
    chk("t6_rst_rdata", rd3, 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    do_xfer(1, 32'h10, HSIZE_DWORD, 0, 64'h0, rdv, w, rf, rl);
    chk("t6_after_resp", 64'(rf | rl), 64'd0);
    chk("t6_after_data", rdv, t4_val);

    p_valid = 1'b0; p_wr = 1'b0; p_wd = '0; p_exp = '0;
    for (int i = 0; i < 120; i++) begin
      @(negedge HCLK);
      if (p_valid) begin
        HWDATA = p_wd;
        chk("rnd_ready", 64'(rdy0), 64'd1);
        chk("rnd_resp", 64'(resp0), 64'd0);
        if (!p_wr) chk("rnd_rdata", rd0, p_exp);
      end
      if (i >= 8 && $urandom_range(0, 4) == 0) begin
        kind   = $urandom_range(0, 2);
        hsel0  = (kind != 0);
        HTRANS = (kind == 1) ? HTRANS_IDLE : ((kind == 2) ? HTRANS_BUSY : HTRANS_NONSEQ);
        HADDR  = 32'h100 + 32'($urandom_range(0, 63));
        HWRITE = 1'($urandom_range(0, 1));
        p_valid = 1'b0;
      end else begin
        word = (i < 8) ? i : $urandom_range(0, 7);
        sz   = (i < 8) ? 3 : $urandom_range(0, 3);
        off  = $urandom_range(0, 7) & ~((1 << sz) - 1);
        wr   = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
        wd   = {$urandom, $urandom};
        hsel0  = 1'b1;
        HTRANS = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
        HADDR  = 32'h100 + 32'(word * 8 + off);
        HSIZE  = 3'(sz);
        HWRITE = wr;
        if (wr) begin
          t = ref_mem[word];
          for (int b = off; b < off + (1 << sz); b++) t[b*8 +: 8] = wd[b*8 +: 8];
          ref_mem[word] = t;
        end else begin
          p_exp = ref_mem[word];
        end
        p_valid = 1'b1; p_wr = wr; p_wd = wd;
      end
    end
    @(negedge HCLK);
    hsel0 = 1'b0; HTRANS = HTRANS_IDLE;
    if (p_valid) begin
      HWDATA = p_wd;
      if (!p_wr) chk("rnd_rdata_last", rd0, p_exp);
    end
    @(negedge HCLK);
    for (int k = 0; k < 8; k++) begin
      do_xfer(0, 32'h100 + 32'(k * 8), HSIZE_DWORD, 0, 64'h0, rdv, w, rf, rl);
      chk("rnd_final_word", rdv, ref_mem[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
